// File: rtl/stream_sched_pkg.sv
// Shared types and helpers for the stream rate scheduler.
package stream_sched_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SELECT  = 2'd1,
        MEASURE = 2'd2,
        REPORT  = 2'd3
    } state_t;

    localparam int SAT_W = 64;

    // Full-precision product clamped to the largest value that fits in outW bits.
    function automatic logic [SAT_W-1:0] sat_mul(
        input logic [SAT_W-1:0] a,
        input logic [SAT_W-1:0] b,
        input int               outW
    );
        logic [2*SAT_W-1:0] prod;
        logic [2*SAT_W-1:0] limit;
        prod  = {{SAT_W{1'b0}}, a} * {{SAT_W{1'b0}}, b};
        limit = (128'(1) << outW) - 128'(1);
        return (prod > limit) ? limit[SAT_W-1:0] : prod[SAT_W-1:0];
    endfunction

endpackage

// File: rtl/rr_next_ch.sv
// Round-robin picker: lowest set mask bit strictly after last_ch, wrapping around.
module rr_next_ch #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] mask,
    input  logic [CH_W-1:0]   last_ch,
    output logic [CH_W-1:0]   next_ch,
    output logic              any
);

    logic [CH_W-1:0] w_hiCh;
    logic [CH_W-1:0] w_loCh;
    logic            w_hiFound;

    // Scanning downward lets the lowest qualifying index win in each half.
    always_comb begin
        w_hiCh    = '0;
        w_loCh    = '0;
        w_hiFound = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                if (CH_W'(i) > last_ch) begin
                    w_hiCh    = CH_W'(i);
                    w_hiFound = 1'b1;
                end else begin
                    w_loCh = CH_W'(i);
                end
            end
        end
    end

    assign next_ch = w_hiFound ? w_hiCh : w_loCh;
    assign any     = |mask;

endmodule

// File: rtl/stream_rate_scheduler.sv
// Shares one beat-counting window across NUM_CH observed streams, round-robin,
// and reports per-window beat/bit counts through a one-deep result register.
module stream_rate_scheduler #(
    parameter int NUM_CH        = 4,
    parameter int DATA_WIDTH    = 256,
    parameter int COUNTER_WIDTH = 32,
    parameter int CH_W          = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_CH-1:0]        s_valid,
    input  logic [NUM_CH-1:0]        s_ready,
    input  logic                     enable,
    input  logic [NUM_CH-1:0]        ch_mask,
    input  logic [COUNTER_WIDTH-1:0] window_clks,
    output logic                     busy,
    output logic                     result_valid,
    input  logic                     result_ready,
    output logic [CH_W-1:0]          result_ch,
    output logic [COUNTER_WIDTH-1:0] result_beats,
    output logic [COUNTER_WIDTH-1:0] result_bits,
    output logic                     overrun,
    input  logic                     overrun_clear
);
    import stream_sched_pkg::*;

    state_t                   r_state;
    logic                     r_busy;
    logic [CH_W-1:0]          r_lastCh;
    logic [CH_W-1:0]          r_ch;
    logic [COUNTER_WIDTH-1:0] r_lastIdx;
    logic [COUNTER_WIDTH-1:0] r_timer;
    logic [COUNTER_WIDTH-1:0] r_beats;
    logic                     r_resultValid;
    logic [CH_W-1:0]          r_resultCh;
    logic [COUNTER_WIDTH-1:0] r_resultBeats;
    logic [COUNTER_WIDTH-1:0] r_resultBits;
    logic                     r_overrun;

    logic [CH_W-1:0]          w_nextCh;
    logic                     w_any;
    logic                     w_hs;
    logic [COUNTER_WIDTH-1:0] w_lastIdx;

    rr_next_ch #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_rr (
        .mask    (ch_mask),
        .last_ch (r_lastCh),
        .next_ch (w_nextCh),
        .any     (w_any)
    );

    assign w_hs      = s_valid[r_ch] & s_ready[r_ch];
    // A zero length behaves as a one-clock window, so the last timer index is 0.
    assign w_lastIdx = (window_clks == '0) ? '0 : window_clks - 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_busy        <= 1'b0;
            r_lastCh      <= CH_W'(NUM_CH - 1);
            r_ch          <= '0;
            r_lastIdx     <= '0;
            r_timer       <= '0;
            r_beats       <= '0;
            r_resultValid <= 1'b0;
            r_resultCh    <= '0;
            r_resultBeats <= '0;
            r_resultBits  <= '0;
            r_overrun     <= 1'b0;
        end else begin
            if (r_resultValid && result_ready) begin
                r_resultValid <= 1'b0;
            end
            if (overrun_clear) begin
                r_overrun <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (enable && w_any) begin
                        r_state <= SELECT;
                        r_busy  <= 1'b1;
                    end
                end
                SELECT: begin
                    // With the mask emptied since IDLE there is nothing to measure.
                    if (w_any) begin
                        r_ch      <= w_nextCh;
                        r_lastIdx <= w_lastIdx;
                        r_timer   <= '0;
                        r_beats   <= '0;
                        r_state   <= MEASURE;
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                MEASURE: begin
                    if (!enable) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        if (w_hs && (r_beats != '1)) begin
                            r_beats <= r_beats + 1'b1;
                        end
                        r_timer <= r_timer + 1'b1;
                        if (r_timer == r_lastIdx) begin
                            r_state <= REPORT;
                        end
                    end
                end
                REPORT: begin
                    r_resultValid <= 1'b1;
                    r_resultCh    <= r_ch;
                    r_resultBeats <= r_beats;
                    r_resultBits  <= COUNTER_WIDTH'(sat_mul(64'(r_beats), 64'(DATA_WIDTH), COUNTER_WIDTH));
                    r_lastCh      <= r_ch;
                    if (r_resultValid && !result_ready) begin
                        r_overrun <= 1'b1;
                    end
                    if (enable && w_any) begin
                        r_state <= SELECT;
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy         = r_busy;
    assign result_valid = r_resultValid;
    assign result_ch    = r_resultCh;
    assign result_beats = r_resultBeats;
    assign result_bits  = r_resultBits;
    assign overrun      = r_overrun;

endmodule

// File: tb/tb_stream_rate_scheduler.sv
// Self-checking bench: directed window table, hand-written corner sequences and
// randomized handshakes compared against a window-arithmetic reference model.
module tb_stream_rate_scheduler;

    localparam int HS_PATTERN = 0;
    localparam int HS_RANDOM  = 1;
    localparam int HS_ALL     = 2;

    logic        clk;
    logic        reset_n;
    logic [3:0]  s_valid;
    logic [3:0]  s_ready;
    logic        enable;
    logic [3:0]  ch_mask;
    logic [31:0] window_clks;
    logic        busy;
    logic        result_valid;
    logic        result_ready;
    logic [1:0]  result_ch;
    logic [31:0] result_beats;
    logic [31:0] result_bits;
    logic        overrun;
    logic        overrun_clear;

    logic        satEnable;
    logic [3:0]  satMask;
    logic [7:0]  satWin;
    logic        satBusy;
    logic        satValid;
    logic        satReady;
    logic [1:0]  satCh;
    logic [7:0]  satBeats;
    logic [7:0]  satBits;
    logic        satOverrun;
    logic        satOvClear;

    int              checks = 0;
    int              errors = 0;
    int              cycleCnt = 0;
    int              hsMode = HS_ALL;
    logic [3:0][3:0] hsEvery;
    logic [3:0]      hsLog[$];

    typedef struct {
        logic [3:0]      mask;
        logic [31:0]     win;
        logic [3:0][3:0] every;
        int              lat;
        int              firstCh;
        int              firstBeats;
        int              firstBits;
        int              nextCh;
        int              nextBeats;
        int              nextBits;
        int              per;
    } vec_t;

    vec_t vecs[5];

    stream_rate_scheduler #(
        .NUM_CH        (4),
        .DATA_WIDTH    (256),
        .COUNTER_WIDTH (32)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .enable        (enable),
        .ch_mask       (ch_mask),
        .window_clks   (window_clks),
        .busy          (busy),
        .result_valid  (result_valid),
        .result_ready  (result_ready),
        .result_ch     (result_ch),
        .result_beats  (result_beats),
        .result_bits   (result_bits),
        .overrun       (overrun),
        .overrun_clear (overrun_clear)
    );

    stream_rate_scheduler #(
        .NUM_CH        (4),
        .DATA_WIDTH    (256),
        .COUNTER_WIDTH (8)
    ) dutSat (
        .clk           (clk),
        .reset_n       (reset_n),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .enable        (satEnable),
        .ch_mask       (satMask),
        .window_clks   (satWin),
        .busy          (satBusy),
        .result_valid  (satValid),
        .result_ready  (satReady),
        .result_ch     (satCh),
        .result_beats  (satBeats),
        .result_bits   (satBits),
        .overrun       (satOverrun),
        .overrun_clear (satOvClear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: drive handshakes for the coming edge, log them, land on the next falling edge.
    task automatic applyStimulus();
        case (hsMode)
            HS_PATTERN: begin
                s_valid = 4'hF;
                for (int c = 0; c < 4; c++) begin
                    s_ready[c] = (hsEvery[c] == 4'd0) ? 1'b0 : ((cycleCnt % int'(hsEvery[c])) == 0);
                end
            end
            HS_RANDOM: begin
                s_valid = 4'($urandom_range(0, 15));
                s_ready = 4'($urandom_range(0, 15));
            end
            default: begin
                s_valid = 4'hF;
                s_ready = 4'hF;
            end
        endcase
        hsLog.push_back(s_valid & s_ready);
        @(posedge clk);
        cycleCnt++;
        @(negedge clk);
    endtask

    task automatic waitValid(input int limit, output int steps);
        steps = 0;
        do begin
            applyStimulus();
            steps++;
        end while (!result_valid && steps < limit);
        checkOutput("wait_result_valid", result_valid, 1);
    endtask

    task automatic doReset();
        enable        = 1'b0;
        satEnable     = 1'b0;
        overrun_clear = 1'b0;
        satOvClear    = 1'b0;
        result_ready  = 1'b1;
        satReady      = 1'b1;
        reset_n       = 1'b0;
        applyStimulus();
        applyStimulus();
        reset_n = 1'b1;
    endtask

    function automatic int refNext(input logic [3:0] m, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (m[(last + k) % 4]) return (last + k) % 4;
        end
        return last;
    endfunction

    // Expected results follow from the window schedule: report n lands W+2 clocks after report n-1.
    task automatic runRandomEpisode(input int ep);
        int         we;
        int         epStart;
        int         nSteps;
        int         rel;
        int         n;
        int         beats;
        int         last;
        int         chSeq[4];
        logic [3:0] hs;
        logic       isRep;
        doReset();
        ch_mask      = 4'($urandom_range(1, 15));
        window_clks  = 32'($urandom_range(0, 6));
        we           = (window_clks == 0) ? 1 : int'(window_clks);
        hsMode       = HS_RANDOM;
        result_ready = 1'b1;
        enable       = 1'b1;
        last = 3;
        for (int k = 0; k < 4; k++) begin
            chSeq[k] = refNext(ch_mask, last);
            last     = chSeq[k];
        end
        epStart = cycleCnt;
        nSteps  = 2 + we + 3 * (we + 2) + 1;
        for (int s = 0; s < nSteps; s++) begin
            applyStimulus();
            rel   = s;
            isRep = (rel >= 2 + we) && (((rel - 2 - we) % (we + 2)) == 0);
            checkOutput($sformatf("rnd%0d_valid@%0d", ep, rel), result_valid, isRep);
            checkOutput($sformatf("rnd%0d_busy@%0d", ep, rel), busy, 1);
            if (isRep) begin
                n     = (rel - 2 - we) / (we + 2);
                beats = 0;
                for (int j = 0; j < we; j++) begin
                    hs = hsLog[epStart + 2 + n * (we + 2) + j];
                    if (hs[chSeq[n]]) beats++;
                end
                checkOutput($sformatf("rnd%0d_ch%0d", ep, n), result_ch, chSeq[n]);
                checkOutput($sformatf("rnd%0d_beats%0d", ep, n), result_beats, beats);
                checkOutput($sformatf("rnd%0d_bits%0d", ep, n), result_bits, beats * 256);
            end
        end
        checkOutput($sformatf("rnd%0d_overrun", ep), overrun, 0);
        enable = 1'b0;
    endtask

    initial begin
        int steps;

        vecs[0] = '{mask: 4'b0101, win: 32'd10, every: {4'd0, 4'd2, 4'd0, 4'd1}, lat: 13,
                    firstCh: 0, firstBeats: 10, firstBits: 2560, nextCh: 2, nextBeats: 5, nextBits: 1280, per: 12};
        vecs[1] = '{mask: 4'b0001, win: 32'd0, every: {4'd0, 4'd0, 4'd0, 4'd1}, lat: 4,
                    firstCh: 0, firstBeats: 1, firstBits: 256, nextCh: 0, nextBeats: 1, nextBits: 256, per: 3};
        vecs[2] = '{mask: 4'b1010, win: 32'd3, every: {4'd1, 4'd0, 4'd1, 4'd0}, lat: 6,
                    firstCh: 1, firstBeats: 3, firstBits: 768, nextCh: 3, nextBeats: 3, nextBits: 768, per: 5};
        vecs[3] = '{mask: 4'b1000, win: 32'd4, every: {4'd0, 4'd0, 4'd0, 4'd1}, lat: 7,
                    firstCh: 3, firstBeats: 0, firstBits: 0, nextCh: 3, nextBeats: 0, nextBits: 0, per: 6};
        vecs[4] = '{mask: 4'b0110, win: 32'd6, every: {4'd0, 4'd1, 4'd3, 4'd0}, lat: 9,
                    firstCh: 1, firstBeats: 2, firstBits: 512, nextCh: 2, nextBeats: 6, nextBits: 1536, per: 8};

        s_valid     = '0;
        s_ready     = '0;
        ch_mask     = '0;
        window_clks = '0;
        satMask     = 4'b0001;
        satWin      = 8'd255;
        hsEvery     = '0;

        doReset();
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_valid", result_valid, 0);
        checkOutput("rst_ch", result_ch, 0);
        checkOutput("rst_beats", result_beats, 0);
        checkOutput("rst_bits", result_bits, 0);
        checkOutput("rst_overrun", overrun, 0);

        for (int i = 0; i < 5; i++) begin
            doReset();
            ch_mask      = vecs[i].mask;
            window_clks  = vecs[i].win;
            hsEvery      = vecs[i].every;
            hsMode       = HS_PATTERN;
            result_ready = 1'b1;
            enable       = 1'b1;
            waitValid(100, steps);
            checkOutput($sformatf("tbl%0d_latency", i), steps, vecs[i].lat);
            checkOutput($sformatf("tbl%0d_ch_a", i), result_ch, vecs[i].firstCh);
            checkOutput($sformatf("tbl%0d_beats_a", i), result_beats, vecs[i].firstBeats);
            checkOutput($sformatf("tbl%0d_bits_a", i), result_bits, vecs[i].firstBits);
            waitValid(100, steps);
            checkOutput($sformatf("tbl%0d_period", i), steps, vecs[i].per);
            checkOutput($sformatf("tbl%0d_ch_b", i), result_ch, vecs[i].nextCh);
            checkOutput($sformatf("tbl%0d_beats_b", i), result_beats, vecs[i].nextBeats);
            checkOutput($sformatf("tbl%0d_bits_b", i), result_bits, vecs[i].nextBits);
            enable = 1'b0;
        end

        // Overrun with clear colliding on the overwriting edge, then drain and clear.
        doReset();
        ch_mask      = 4'b0011;
        window_clks  = 32'd4;
        hsEvery      = {4'd0, 4'd0, 4'd2, 4'd1};
        hsMode       = HS_PATTERN;
        result_ready = 1'b0;
        enable       = 1'b1;
        waitValid(50, steps);
        checkOutput("ovr_first_ch", result_ch, 0);
        checkOutput("ovr_first_beats", result_beats, 4);
        checkOutput("ovr_first_flag", overrun, 0);
        for (int k = 1; k <= 6; k++) begin
            overrun_clear = (k == 6);
            applyStimulus();
            if (k == 3) begin
                checkOutput("ovr_hold_valid", result_valid, 1);
                checkOutput("ovr_hold_ch", result_ch, 0);
                checkOutput("ovr_hold_beats", result_beats, 4);
            end
        end
        overrun_clear = 1'b0;
        enable        = 1'b0;
        checkOutput("ovr_valid", result_valid, 1);
        checkOutput("ovr_ch", result_ch, 1);
        checkOutput("ovr_beats", result_beats, 2);
        checkOutput("ovr_bits", result_bits, 512);
        checkOutput("ovr_flag_set_wins", overrun, 1);
        result_ready = 1'b1;
        applyStimulus();
        checkOutput("ovr_drain_valid", result_valid, 0);
        checkOutput("ovr_drain_flag", overrun, 1);
        result_ready  = 1'b0;
        overrun_clear = 1'b1;
        applyStimulus();
        overrun_clear = 1'b0;
        checkOutput("ovr_cleared", overrun, 0);
        checkOutput("ovr_idle_busy", busy, 0);

        // Overwrite accepted on the same edge must not raise overrun.
        enable = 1'b1;
        waitValid(50, steps);
        checkOutput("acc_first_ch", result_ch, 0);
        for (int k = 1; k <= 6; k++) begin
            result_ready = (k == 6);
            applyStimulus();
        end
        enable = 1'b0;
        checkOutput("acc_valid", result_valid, 1);
        checkOutput("acc_ch", result_ch, 1);
        checkOutput("acc_overrun", overrun, 0);
        result_ready = 1'b1;
        applyStimulus();
        applyStimulus();

        // Abort on the 4th MEASURE clock of the ch2 window, then re-measure ch2.
        doReset();
        ch_mask      = 4'b0101;
        window_clks  = 32'd10;
        hsMode       = HS_ALL;
        result_ready = 1'b1;
        enable       = 1'b1;
        waitValid(50, steps);
        checkOutput("abt_first_ch", result_ch, 0);
        for (int k = 1; k <= 5; k++) begin
            enable = (k < 5);
            applyStimulus();
        end
        checkOutput("abt_busy", busy, 0);
        checkOutput("abt_valid", result_valid, 0);
        applyStimulus();
        checkOutput("abt_busy_after", busy, 0);
        checkOutput("abt_valid_after", result_valid, 0);
        enable = 1'b1;
        waitValid(50, steps);
        checkOutput("abt_relatency", steps, 13);
        checkOutput("abt_retry_ch", result_ch, 2);
        checkOutput("abt_retry_beats", result_beats, 10);
        enable = 1'b0;

        // Asynchronous reset landing between edges in the middle of a window.
        doReset();
        ch_mask      = 4'b1111;
        window_clks  = 32'd5;
        hsMode       = HS_ALL;
        result_ready = 1'b0;
        enable       = 1'b1;
        waitValid(50, steps);
        applyStimulus();
        applyStimulus();
        applyStimulus();
        checkOutput("ar_pre_valid", result_valid, 1);
        checkOutput("ar_pre_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        checkOutput("ar_busy", busy, 0);
        checkOutput("ar_valid", result_valid, 0);
        checkOutput("ar_ch", result_ch, 0);
        checkOutput("ar_beats", result_beats, 0);
        checkOutput("ar_bits", result_bits, 0);
        checkOutput("ar_overrun", overrun, 0);
        applyStimulus();
        applyStimulus();
        reset_n      = 1'b1;
        result_ready = 1'b1;
        waitValid(50, steps);
        checkOutput("ar_restart_latency", steps, 8);
        checkOutput("ar_restart_ch", result_ch, 0);
        enable = 1'b0;

        // Narrow counters: 255 beats of 256 bits must clamp the bit count.
        doReset();
        hsMode    = HS_ALL;
        satEnable = 1'b1;
        steps     = 0;
        do begin
            applyStimulus();
            steps++;
        end while (!satValid && steps < 400);
        checkOutput("sat_valid", satValid, 1);
        checkOutput("sat_latency", steps, 258);
        checkOutput("sat_ch", satCh, 0);
        checkOutput("sat_beats", satBeats, 255);
        checkOutput("sat_bits", satBits, 255);
        satEnable = 1'b0;

        for (int ep = 0; ep < 6; ep++) begin
            runRandomEpisode(ep);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
